nbit_cla_adder: RTL and testbench



---
 rtl/nbit_cla_adder.sv | 118 +++++++++++
 tb/tb_nbit_cla_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nbit_cla_adder.sv
// N-bit two-level carry-lookahead adder: 4-bit lookahead groups feeding a
// group-lookahead unit, with sum and carry-out captured in output registers.
module nbit_cla_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    input  logic         cin,
    output logic         cout
);

    localparam int NG = (N + 3) / 4;
    localparam int NP = NG * 4;

    logic [NP-1:0] w_a_pad;
    logic [NP-1:0] w_b_pad;
    logic [NP-1:0] w_g;
    logic [NP-1:0] w_p;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic [NG:0]   w_grp_cin;
    logic [NP:0]   w_carry;
    logic [N-1:0]  w_sum;
    logic [N-1:0]  r_sum;
    logic          r_cout;

    // Internal carries c0..c3 of one group, each a flat sum of products.
    function automatic logic [3:0] group_carries(input logic [3:0] g,
                                                 input logic [3:0] p,
                                                 input logic       c0);
        logic [3:0] c;
        logic       term;
        c    = 4'b0000;
        c[0] = c0;
        for (int j = 0; j < 3; j++) begin
            c[j+1] = 1'b0;
            for (int k = 0; k <= j; k++) begin
                term = g[k];
                for (int m = k + 1; m <= j; m++) term = term & p[m];
                c[j+1] = c[j+1] | term;
            end
            term = c0;
            for (int m = 0; m <= j; m++) term = term & p[m];
            c[j+1] = c[j+1] | term;
        end
        return c;
    endfunction

    function automatic logic group_generate(input logic [3:0] g,
                                            input logic [3:0] p);
        logic gg;
        logic term;
        gg = 1'b0;
        for (int k = 0; k < 4; k++) begin
            term = g[k];
            for (int m = k + 1; m < 4; m++) term = term & p[m];
            gg = gg | term;
        end
        return gg;
    endfunction

    // Every group carry-in is expanded directly from GG/GP and the carry-in.
    function automatic logic [NG:0] lookahead_carries(input logic [NG-1:0] gg,
                                                      input logic [NG-1:0] gp,
                                                      input logic          c0);
        logic [NG:0] c;
        logic        term;
        c    = {(NG+1){1'b0}};
        c[0] = c0;
        for (int k = 1; k <= NG; k++) begin
            c[k] = 1'b0;
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int m = j + 1; m < k; m++) term = term & gp[m];
                c[k] = c[k] | term;
            end
            term = c0;
            for (int m = 0; m < k; m++) term = term & gp[m];
            c[k] = c[k] | term;
        end
        return c;
    endfunction

    // Pad bits above N are zero, so they behave as g=0, p=0.
    assign w_a_pad = NP'(a);
    assign w_b_pad = NP'(b);
    assign w_g     = w_a_pad & w_b_pad;
    assign w_p     = w_a_pad ^ w_b_pad;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        assign w_gg[k]          = group_generate(w_g[4*k +: 4], w_p[4*k +: 4]);
        assign w_gp[k]          = &w_p[4*k +: 4];
        assign w_carry[4*k +: 4] = group_carries(w_g[4*k +: 4], w_p[4*k +: 4],
                                                 w_grp_cin[k]);
    end

    assign w_grp_cin   = lookahead_carries(w_gg, w_gp, cin);
    assign w_carry[NP] = w_grp_cin[NG];
    assign w_sum       = w_p[N-1:0] ^ w_carry[N-1:0];

    // Output registers; reset clears them immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= {N{1'b0}};
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[N];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_nbit_cla_adder.sv
// Self-checking bench for nbit_cla_adder at N = 4, 5, 8, 16 and 32 against
// a plain-arithmetic a + b + cin reference.
module tb_nbit_cla_adder;

    logic        clk;
    logic        rst;
    logic [3:0]  a4,  b4,  s4;
    logic [4:0]  a5,  b5,  s5;
    logic [7:0]  a8,  b8,  s8;
    logic [15:0] a16, b16, s16;
    logic [31:0] a32, b32, s32;
    logic        ci4, ci5, ci8, ci16, ci32;
    logic        co4, co5, co8, co16, co32;

    int n_cmp = 0;
    int n_err = 0;

    nbit_cla_adder #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .a(a4),  .b(b4),  .sum(s4),  .cin(ci4),  .cout(co4));
    nbit_cla_adder #(.N(5))  u_dut5  (.clk(clk), .rst(rst), .a(a5),  .b(b5),  .sum(s5),  .cin(ci5),  .cout(co5));
    nbit_cla_adder #(.N(8))  u_dut8  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .sum(s8),  .cin(ci8),  .cout(co8));
    nbit_cla_adder #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .sum(s16), .cin(ci16), .cout(co16));
    nbit_cla_adder #(.N(32)) u_dut32 (.clk(clk), .rst(rst), .a(a32), .b(b32), .sum(s32), .cin(ci32), .cout(co32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [8:0] exp8;
        rst = 1'b1;
        a8 = 8'hAB; b8 = 8'hCD; ci8 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; ci4 = 1'b1;
        a5 = 5'h1F; b5 = 5'h1F; ci5 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; ci32 = 1'b1;
        #2;
        n_cmp++;
        if ({co8, s8} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_immediate: got %h expected %h", {co8, s8}, 9'h000);
        end
        tick; tick;
        n_cmp++;
        if ({co4, s4, co5, s5, co8, s8, co16, s16, co32, s32} !== 70'd0) begin
            n_err++;
            $display("FAIL reset_held: got %h expected 0", {co4, s4, co5, s5, co8, s8, co16, s16, co32, s32});
        end
        @(negedge clk);
        rst = 1'b0;
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
        tick;
        n_cmp++;
        if ({co8, s8} !== 9'h047) begin
            n_err++;
            $display("FAIL first_after_reset: got %h expected %h", {co8, s8}, 9'h047);
        end
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        tick;
        exp8 = 9'h1FF;
        n_cmp++;
        if ({co8, s8} !== exp8) begin
            n_err++;
            $display("FAIL pre_midstream_reset: got %h expected %h", {co8, s8}, exp8);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({co8, s8} !== 9'h000) begin
            n_err++;
            $display("FAIL reset_midstream: got %h expected %h", {co8, s8}, 9'h000);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [7:0] va [6] = '{8'hF0, 8'hAF, 8'hFF, 8'h7F, 8'hFF, 8'h00};
        logic [7:0] vb [6] = '{8'hC0, 8'h5C, 8'h00, 8'h01, 8'hFF, 8'h00};
        logic       vc [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        logic [8:0] ve [6] = '{9'h1B0, 9'h10B, 9'h100, 9'h080, 9'h1FF, 9'h000};
        for (int i = 0; i < 6; i++) begin
            a8 = va[i]; b8 = vb[i]; ci8 = vc[i];
            tick;
            n_cmp++;
            if ({co8, s8} !== ve[i]) begin
                n_err++;
                $display("FAIL directed_%0d: got %h expected %h", i, {co8, s8}, ve[i]);
            end
        end
    endtask

    task automatic test_boundary;
        // all-ones + 0 + 1 must carry through every bit of every width
        a4 = '1; b4 = '0; ci4 = 1'b1;
        a5 = '1; b5 = '0; ci5 = 1'b1;
        a8 = '1; b8 = '0; ci8 = 1'b1;
        a16 = '1; b16 = '0; ci16 = 1'b1;
        a32 = '1; b32 = '0; ci32 = 1'b1;
        tick;
        n_cmp++;
        if ({co4, s4, co5, s5, co8, s8, co16, s16, co32, s32} !==
            {1'b1, 4'h0, 1'b1, 5'h00, 1'b1, 8'h00, 1'b1, 16'h0000, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL full_propagate: got %h", {co4, s4, co5, s5, co8, s8, co16, s16, co32, s32});
        end
        b4 = '1; b5 = '1; b8 = '1; b16 = '1; b32 = '1;
        tick;
        n_cmp++;
        if ({co4, s4, co5, s5, co8, s8, co16, s16, co32, s32} !==
            {1'b1, 4'hF, 1'b1, 5'h1F, 1'b1, 8'hFF, 1'b1, 16'hFFFF, 1'b1, 32'hFFFF_FFFF}) begin
            n_err++;
            $display("FAIL all_ones: got %h", {co4, s4, co5, s5, co8, s8, co16, s16, co32, s32});
        end
    endtask

    task automatic test_latency;
        logic [8:0] prev;
        logic [8:0] exp8;
        logic [7:0] ra, rb;
        logic       rc;
        prev = {co8, s8};
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
            exp8 = 9'(ra) + 9'(rb) + 9'(rc);
            a8 = ~ra; b8 = 8'($urandom); ci8 = ~rc;
            #3;
            n_cmp++;
            if ({co8, s8} !== prev) begin
                n_err++;
                $display("FAIL mid_cycle_hold_%0d: got %h expected %h", i, {co8, s8}, prev);
            end
            @(negedge clk);
            a8 = ra; b8 = rb; ci8 = rc;
            #1;
            n_cmp++;
            if ({co8, s8} !== prev) begin
                n_err++;
                $display("FAIL pre_edge_hold_%0d: got %h expected %h", i, {co8, s8}, prev);
            end
            tick;
            n_cmp++;
            if ({co8, s8} !== exp8) begin
                n_err++;
                $display("FAIL latency_%0d: got %h expected %h", i, {co8, s8}, exp8);
            end
            prev = exp8;
        end
    endtask

    task automatic test_random;
        logic [4:0]  e4;
        logic [5:0]  e5;
        logic [8:0]  e8;
        logic [16:0] e16;
        logic [32:0] e32;
        for (int i = 0; i < 10000; i++) begin
            a4 = 4'($urandom);   b4 = 4'($urandom);   ci4 = 1'($urandom_range(0, 1));
            a5 = 5'($urandom);   b5 = 5'($urandom);   ci5 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);   b8 = 8'($urandom);   ci8 = 1'($urandom_range(0, 1));
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom_range(0, 1));
            a32 = $urandom;      b32 = $urandom;      ci32 = 1'($urandom_range(0, 1));
            e4  = 5'(a4) + 5'(b4) + 5'(ci4);
            e5  = 6'(a5) + 6'(b5) + 6'(ci5);
            e8  = 9'(a8) + 9'(b8) + 9'(ci8);
            e16 = 17'(a16) + 17'(b16) + 17'(ci16);
            e32 = 33'(a32) + 33'(b32) + 33'(ci32);
            tick;
            n_cmp += 5;
            if ({co4, s4} !== e4) begin
                n_err++;
                $display("FAIL random_n4_%0d: got %h expected %h", i, {co4, s4}, e4);
            end
            if ({co5, s5} !== e5) begin
                n_err++;
                $display("FAIL random_n5_%0d: got %h expected %h", i, {co5, s5}, e5);
            end
            if ({co8, s8} !== e8) begin
                n_err++;
                $display("FAIL random_n8_%0d: got %h expected %h", i, {co8, s8}, e8);
            end
            if ({co16, s16} !== e16) begin
                n_err++;
                $display("FAIL random_n16_%0d: got %h expected %h", i, {co16, s16}, e16);
            end
            if ({co32, s32} !== e32) begin
                n_err++;
                $display("FAIL random_n32_%0d: got %h expected %h", i, {co32, s32}, e32);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_boundary;
        test_latency;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
